// File: rtl/dirty_status_array.sv
// Per-way dirty-bit array with a flush sequencer.
// The sequencer walks every set once and issues a writeback for each dirty line.
module dirty_status_array #(
  parameter int              SETS       = 4,
  parameter int              IDX_W      = 2,
  parameter logic [SETS-1:0] INIT_DIRTY = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_dirty,
  input  logic [IDX_W-1:0] rd_index,
  output logic             dirty_out,
  output logic [SETS-1:0]  dirty_vec,
  output logic [IDX_W:0]   dirty_count,
  input  logic             flush_req,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_index,
  input  logic             wb_ready,
  output logic             busy,
  output logic             flush_done,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

  function automatic logic [IDX_W:0] popcount(input logic [SETS-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < SETS; i++) begin
      c = c + (IDX_W+1)'(v[i]);
    end
    return c;
  endfunction

  localparam logic [IDX_W:0] INIT_COUNT = popcount(INIT_DIRTY);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [IDX_W:0]   count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      dirty_q <= INIT_DIRTY;
      count_q <= INIT_COUNT;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dirty_q <= dirty_d;
      // Count is taken from the next-state vector so it never lags dirty_vec.
      count_q <= popcount(dirty_d);
    end
  end

  // Writeback handshake: wb_valid and wb_index are held stable while in WB;
  // the transfer happens on a rising edge where wb_valid && wb_ready, which
  // also clears the dirty bit of that set.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dirty_d = dirty_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          dirty_d[wr_index] = wr_dirty;
        end
        if (flush_req) begin
          state_d = ST_SCAN;
          ptr_d   = '0;
        end
      end
      ST_SCAN: begin
        if (dirty_q[ptr_q]) begin
          state_d = ST_WB;
        end else if (ptr_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          dirty_d[ptr_q] = 1'b0;
          if (ptr_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SCAN;
            ptr_d   = ptr_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dirty_vec   = dirty_q;
  assign dirty_out   = dirty_q[rd_index];
  assign dirty_count = count_q;
  assign wb_valid    = (state_q == ST_WB);
  assign wb_index    = ptr_q;
  assign busy        = (state_q != ST_IDLE);
  assign flush_done  = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dirty_status_array.sv
// Directed bench for dirty_status_array: write path, lookup, flush, backpressure,
// blocked writes, mid-flush reset abort and clean-array flush timing.
module tb_dirty_status_array;

  logic       clk = 1'b0;
  logic       reset, wr_en, wr_dirty, flush_req, wb_ready;
  logic [1:0] wr_index, rd_index;
  logic       dirty_out, wb_valid, busy, flush_done;
  logic [3:0] dirty_vec;
  logic [2:0] dirty_count;
  logic [1:0] wb_index, dbg_state;

  logic       reset1, wr_en1, wr_dirty1, flush_req1, wb_ready1;
  logic [1:0] wr_index1, rd_index1;
  logic       dirty_out1, wb_valid1, busy1, flush_done1;
  logic [3:0] dirty_vec1;
  logic [2:0] dirty_count1;
  logic [1:0] wb_index1, dbg_state1;

  int tests_run    = 0;
  int tests_failed = 0;

  dirty_status_array #(.SETS(4), .IDX_W(2), .INIT_DIRTY(4'b0000)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_dirty(wr_dirty),
    .rd_index(rd_index), .dirty_out(dirty_out), .dirty_vec(dirty_vec),
    .dirty_count(dirty_count), .flush_req(flush_req), .wb_valid(wb_valid),
    .wb_index(wb_index), .wb_ready(wb_ready), .busy(busy), .flush_done(flush_done),
    .dbg_state_o(dbg_state)
  );

  dirty_status_array #(.SETS(4), .IDX_W(2), .INIT_DIRTY(4'b1111)) dut1 (
    .clk(clk), .reset(reset1), .wr_en(wr_en1), .wr_index(wr_index1), .wr_dirty(wr_dirty1),
    .rd_index(rd_index1), .dirty_out(dirty_out1), .dirty_vec(dirty_vec1),
    .dirty_count(dirty_count1), .flush_req(flush_req1), .wb_valid(wb_valid1),
    .wb_index(wb_index1), .wb_ready(wb_ready1), .busy(busy1), .flush_done(flush_done1),
    .dbg_state_o(dbg_state1)
  );

  // Clock/reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write0(input logic [1:0] idx, input logic d);
    wr_en    = 1'b1;
    wr_index = idx;
    wr_dirty = d;
    step();
    wr_en    = 1'b0;
  endtask

  logic [3:0] lk;
  int busy_n, fd_at, fd_n, wbv_n, fd1_n;

  initial begin
    reset = 1'b1; wr_en = 0; wr_dirty = 0; flush_req = 0; wb_ready = 0;
    wr_index = 0; rd_index = 0;
    reset1 = 1'b1; wr_en1 = 0; wr_dirty1 = 0; flush_req1 = 0; wb_ready1 = 0;
    wr_index1 = 0; rd_index1 = 0;

    // Asynchronous reset before any clock edge
    #2;
    reset = 1'b0; reset1 = 1'b0;
    #1;
    check("rst_vec",   dirty_vec,   4'b0000);
    check("rst_cnt",   dirty_count, 3'd0);
    check("rst_busy",  busy,        1'b0);
    check("rst_wbv",   wb_valid,    1'b0);
    check("rst_done",  flush_done,  1'b0);
    check("rst_state", dbg_state,   2'd0);
    check("rst_wbidx", wb_index,    2'd0);
    check("rst1_vec",  dirty_vec1,  4'b1111);
    check("rst1_cnt",  dirty_count1, 3'd4);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; reset1 = 1'b1;
    step();

    // Write path
    write0(2'd2, 1'b1);
    check("wr_set_vec", dirty_vec, 4'b0100);
    check("wr_set_cnt", dirty_count, 3'd1);
    rd_index = 2'd2;
    #1;
    check("wr_set_rd", dirty_out, 1'b1);
    write0(2'd2, 1'b0);
    check("wr_clr_vec", dirty_vec, 4'b0000);
    check("wr_clr_cnt", dirty_count, 3'd0);

    // Lookup sweep
    write0(2'd1, 1'b1);
    write0(2'd3, 1'b1);
    check("lk_vec", dirty_vec, 4'b1010);
    check("lk_cnt", dirty_count, 3'd2);
    lk = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rd_index = 2'(i);
      #1;
      check($sformatf("lookup%0d", i), dirty_out, lk[i]);
    end
    write0(2'd1, 1'b0);
    write0(2'd3, 1'b0);
    check("lk_clr_vec", dirty_vec, 4'b0000);

    // Flush of 1001; set 3 written in the same cycle as flush_req
    write0(2'd0, 1'b1);
    wr_en = 1'b1; wr_index = 2'd3; wr_dirty = 1'b1; flush_req = 1'b1; wb_ready = 1'b1;
    step();
    wr_en = 1'b0; flush_req = 1'b0;
    check("fl_c1_vec",   dirty_vec, 4'b1001);
    check("fl_c1_busy",  busy,      1'b1);
    check("fl_c1_wbv",   wb_valid,  1'b0);
    check("fl_c1_state", dbg_state, 2'd1);
    step();
    check("fl_c2_wbv",   wb_valid,  1'b1);
    check("fl_c2_wbidx", wb_index,  2'd0);
    check("fl_c2_state", dbg_state, 2'd2);
    step();
    check("fl_c3_wbv", wb_valid,    1'b0);
    check("fl_c3_vec", dirty_vec,   4'b1000);
    check("fl_c3_cnt", dirty_count, 3'd1);
    wr_en = 1'b1; wr_index = 2'd0; wr_dirty = 1'b1;
    step();
    wr_en = 1'b0;
    check("blk_wr_vec", dirty_vec, 4'b1000);
    check("fl_c4_wbidx", wb_index, 2'd2);
    step();
    check("fl_c5_wbv", wb_valid, 1'b0);
    step();
    check("fl_c6_wbv",   wb_valid, 1'b1);
    check("fl_c6_wbidx", wb_index, 2'd3);
    step();
    check("fl_c7_done",  flush_done,  1'b1);
    check("fl_c7_vec",   dirty_vec,   4'b0000);
    check("fl_c7_cnt",   dirty_count, 3'd0);
    check("fl_c7_state", dbg_state,   2'd3);
    step();
    check("fl_c8_done", flush_done, 1'b0);
    check("fl_c8_busy", busy,       1'b0);

    // Backpressure on set 1; a flush_req during WB must be ignored
    wb_ready = 1'b0;
    write0(2'd1, 1'b1);
    check("bp_vec0", dirty_vec, 4'b0010);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    check("bp_c2_wbv", wb_valid, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp_wbv%0d", k),   wb_valid,  1'b1);
      check($sformatf("bp_wbidx%0d", k), wb_index,  2'd1);
      check($sformatf("bp_vec%0d", k),   dirty_vec, 4'b0010);
      flush_req = (k == 1);
    end
    flush_req = 1'b0;
    wb_ready  = 1'b1;
    step();
    check("bp_rel_wbv",   wb_valid,    1'b0);
    check("bp_rel_vec",   dirty_vec,   4'b0000);
    check("bp_rel_cnt",   dirty_count, 3'd0);
    check("bp_rel_wbidx", wb_index,    2'd2);
    step();
    step();
    check("bp_done", flush_done, 1'b1);
    step();
    check("bp_idle", busy, 1'b0);

    // Clean-array flush timing
    busy_n = 0; fd_at = 0; fd_n = 0; wbv_n = 0;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (busy) busy_n++;
      if (flush_done) begin
        fd_n++;
        fd_at = cyc;
      end
      if (wb_valid) wbv_n++;
      step();
    end
    check("clean_busy_cycles", busy_n, 5);
    check("clean_done_at",     fd_at,  5);
    check("clean_done_pulses", fd_n,   1);
    check("clean_wbv_cycles",  wbv_n,  0);

    // Mid-flush reset abort on the INIT_DIRTY=1111 instance
    check("ab_vec0", dirty_vec1, 4'b1111);
    flush_req1 = 1'b1; wb_ready1 = 1'b1;
    step();
    flush_req1 = 1'b0;
    step();
    check("ab_c2_wbv",   wb_valid1, 1'b1);
    check("ab_c2_wbidx", wb_index1, 2'd0);
    step();
    check("ab_c3_vec", dirty_vec1, 4'b1110);
    wb_ready1 = 1'b0;
    step();
    check("ab_c4_wbv",   wb_valid1, 1'b1);
    check("ab_c4_wbidx", wb_index1, 2'd1);
    check("ab_c4_busy",  busy1,     1'b1);
    #3;
    reset1 = 1'b0;
    #1;
    check("ab_rst_vec",   dirty_vec1,   4'b1111);
    check("ab_rst_cnt",   dirty_count1, 3'd4);
    check("ab_rst_busy",  busy1,        1'b0);
    check("ab_rst_wbv",   wb_valid1,    1'b0);
    check("ab_rst_done",  flush_done1,  1'b0);
    check("ab_rst_state", dbg_state1,   2'd0);
    fd1_n = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (flush_done1) fd1_n++;
    end
    reset1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (flush_done1) fd1_n++;
    end
    check("ab_no_done",  fd1_n,      0);
    check("ab_post_vec", dirty_vec1, 4'b1111);
    check("ab_post_busy", busy1,     1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
